// File: rtl/blob_tracker.sv
// blob_tracker: per-frame centroid/bounding-box accumulator for a thresholded
// pixel stream, with a latched result register and a sticky overrun flag.
module blob_tracker #(
  parameter int MAX_DIM = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        startOfFrame,
  input  logic        endOfLine,
  input  logic        endOfFrame,
  input  logic        pixelValid,
  input  logic [15:0] thresholdedPixel,
  input  logic        resultAck,
  output logic        resultValid,
  output logic [19:0] hitCount,
  output logic [29:0] sumX,
  output logic [29:0] sumY,
  output logic [9:0]  minX,
  output logic [9:0]  maxX,
  output logic [9:0]  minY,
  output logic [9:0]  maxY,
  output logic        overrun
);

  localparam logic [9:0]  MAX_C    = 10'(MAX_DIM);
  localparam logic [15:0] HIT_CODE = 16'h07e0;
  localparam logic [19:0] CNT_MAX  = 20'hFFFFF;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [19:0] cnt_q, cnt_d;
  logic [29:0] sx_q, sx_d, sy_q, sy_d;
  logic [9:0]  mnx_q, mnx_d, mxx_q, mxx_d, mny_q, mny_d, mxy_q, mxy_d;
  logic        latch_q, latch_d;
  logic        rv_q, rv_d, ovr_q, ovr_d;
  logic [19:0] ohc_q, ohc_d;
  logic [29:0] osx_q, osx_d, osy_q, osy_d;
  logic [9:0]  omnx_q, omnx_d, omxx_q, omxx_d, omny_q, omny_d, omxy_q, omxy_d;

  logic        start, frame_on, hit, rv_eff;
  logic [9:0]  bx, by;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v >= MAX_C) ? MAX_C : v + 10'd1;
  endfunction

  // Frame accumulation, coordinate tracking and result latch / handshake.
  always_comb begin
    state_d = state_q;
    x_d = x_q;   y_d = y_q;
    cnt_d = cnt_q; sx_d = sx_q; sy_d = sy_q;
    mnx_d = mnx_q; mxx_d = mxx_q; mny_d = mny_q; mxy_d = mxy_q;
    rv_d = rv_q; ovr_d = ovr_q;
    ohc_d = ohc_q; osx_d = osx_q; osy_d = osy_q;
    omnx_d = omnx_q; omxx_d = omxx_q; omny_d = omny_q; omxy_d = omxy_q;

    // A start (fresh or restart) reinitialises the working set in the same
    // cycle so a coincident pixel lands at (0,0) of the new frame.
    start    = startOfFrame && enable;
    frame_on = start || (state_q == ACTIVE);
    hit      = pixelValid && (thresholdedPixel == HIT_CODE);
    latch_d  = frame_on && endOfFrame;
    bx       = start ? 10'd0 : x_q;
    by       = start ? 10'd0 : y_q;

    if (start) begin
      state_d = ACTIVE;
      x_d = 10'd0; y_d = 10'd0;
      cnt_d = '0; sx_d = '0; sy_d = '0;
      mnx_d = MAX_C; mxx_d = '0; mny_d = MAX_C; mxy_d = '0;
    end

    if (frame_on) begin
      if (hit) begin
        cnt_d = (cnt_d == CNT_MAX) ? cnt_d : cnt_d + 20'd1;
        sx_d  = sx_d + {20'd0, bx};
        sy_d  = sy_d + {20'd0, by};
        if (bx < mnx_d) mnx_d = bx;
        if (bx > mxx_d) mxx_d = bx;
        if (by < mny_d) mny_d = by;
        if (by > mxy_d) mxy_d = by;
      end
      if (pixelValid) begin
        if (endOfLine) begin
          x_d = 10'd0;
          y_d = sat_inc(by);
        end else begin
          x_d = sat_inc(bx);
        end
      end
      if (endOfFrame) state_d = IDLE;
    end

    // An ack in the latch cycle frees the slot before the new result arrives.
    rv_eff = rv_q && !resultAck;
    rv_d   = rv_eff;
    if (latch_q) begin
      if (!rv_eff) begin
        rv_d  = 1'b1;
        ohc_d = cnt_q;
        osx_d = sx_q;
        osy_d = sy_q;
        // Empty frame reports an all-zero box instead of the MAX_DIM/0 seeds.
        if (cnt_q == '0) begin
          omnx_d = '0; omxx_d = '0; omny_d = '0; omxy_d = '0;
        end else begin
          omnx_d = mnx_q; omxx_d = mxx_q; omny_d = mny_q; omxy_d = mxy_q;
        end
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q <= '0; y_q <= '0;
      cnt_q <= '0; sx_q <= '0; sy_q <= '0;
      mnx_q <= '0; mxx_q <= '0; mny_q <= '0; mxy_q <= '0;
      latch_q <= 1'b0; rv_q <= 1'b0; ovr_q <= 1'b0;
      ohc_q <= '0; osx_q <= '0; osy_q <= '0;
      omnx_q <= '0; omxx_q <= '0; omny_q <= '0; omxy_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d; y_q <= y_d;
      cnt_q <= cnt_d; sx_q <= sx_d; sy_q <= sy_d;
      mnx_q <= mnx_d; mxx_q <= mxx_d; mny_q <= mny_d; mxy_q <= mxy_d;
      latch_q <= latch_d; rv_q <= rv_d; ovr_q <= ovr_d;
      ohc_q <= ohc_d; osx_q <= osx_d; osy_q <= osy_d;
      omnx_q <= omnx_d; omxx_q <= omxx_d; omny_q <= omny_d; omxy_q <= omxy_d;
    end
  end

  assign resultValid = rv_q;
  assign overrun     = ovr_q;
  assign hitCount    = ohc_q;
  assign sumX        = osx_q;
  assign sumY        = osy_q;
  assign minX        = omnx_q;
  assign maxX        = omxx_q;
  assign minY        = omny_q;
  assign maxY        = omxy_q;

endmodule

// File: tb/tb_blob_tracker.sv
// Directed bench for blob_tracker: table of 4x3 frames plus corner sequences.
module tb_blob_tracker;

  localparam logic [15:0] HIT = 16'h07e0;

  logic        clk = 1'b0;
  logic        reset, enable, sof, eol, eof, pv, ack;
  logic [15:0] pix;
  logic        rv, ovr;
  logic [19:0] hc;
  logic [29:0] sx, sy;
  logic [9:0]  mnx, mxx, mny, mxy;

  int checks = 0;
  int errors = 0;

  blob_tracker #(.MAX_DIM(1023)) dut (
    .clock(clk), .reset(reset), .enable(enable),
    .startOfFrame(sof), .endOfLine(eol), .endOfFrame(eof),
    .pixelValid(pv), .thresholdedPixel(pix),
    .resultValid(rv), .resultAck(ack),
    .hitCount(hc), .sumX(sx), .sumY(sy),
    .minX(mnx), .maxX(mxx), .minY(mny), .maxY(mxy),
    .overrun(ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [11:0] mask;
    bit          coinc;
    logic [19:0] hc;
    logic [29:0] sx, sy;
    logic [9:0]  mnx, mxx, mny, mxy;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_res(input string tag, input vec_t v);
    check({tag, " resultValid"}, 32'(rv), 32'd1);
    check({tag, " hitCount"}, 32'(hc), 32'(v.hc));
    check({tag, " sumX"}, 32'(sx), 32'(v.sx));
    check({tag, " sumY"}, 32'(sy), 32'(v.sy));
    check({tag, " minX"}, 32'(mnx), 32'(v.mnx));
    check({tag, " maxX"}, 32'(mxx), 32'(v.mxx));
    check({tag, " minY"}, 32'(mny), 32'(v.mny));
    check({tag, " maxY"}, 32'(mxy), 32'(v.mxy));
  endtask

  task automatic clear_in();
    sof = 0; eol = 0; eof = 0; pv = 0; pix = 16'h0000;
  endtask

  // 4x3 frame, raster order; mask bit y*4+x marks a hit. Misses alternate
  // between the two non-hit colours. Returns just after the endOfFrame edge.
  task automatic drive_frame(input logic [11:0] mask, input bit coinc);
    if (!coinc) begin
      sof = 1; step(); sof = 0;
    end
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        pv  = 1;
        pix = mask[y*4+x] ? HIT : ((((x + y) % 2) == 1) ? 16'hF81F : 16'h0000);
        eol = (x == 3);
        eof = (x == 3) && (y == 2);
        sof = coinc && (x == 0) && (y == 0);
        step();
      end
    end
    clear_in();
  endtask

  task automatic do_ack();
    ack = 1; step(); ack = 0;
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{12'h402, 1'b0, 20'd2,  30'd3,  30'd2,  10'd1, 10'd2, 10'd0, 10'd2};
    vecs[1] = '{12'h000, 1'b0, 20'd0,  30'd0,  30'd0,  10'd0, 10'd0, 10'd0, 10'd0};
    vecs[2] = '{12'hFFF, 1'b0, 20'd12, 30'd18, 30'd12, 10'd0, 10'd3, 10'd0, 10'd2};
    vecs[3] = '{12'h080, 1'b0, 20'd1,  30'd3,  30'd1,  10'd3, 10'd3, 10'd1, 10'd1};
    vecs[4] = '{12'h801, 1'b1, 20'd2,  30'd3,  30'd2,  10'd0, 10'd3, 10'd0, 10'd2};
    vecs[5] = '{12'h444, 1'b0, 20'd3,  30'd6,  30'd3,  10'd2, 10'd2, 10'd0, 10'd2};

    reset = 1; enable = 1; ack = 0;
    clear_in();
    step(); step();
    reset = 0;
    check("reset resultValid", 32'(rv), 32'd0);
    check("reset overrun", 32'(ovr), 32'd0);
    check("reset hitCount", 32'(hc), 32'd0);
    check("reset sumX", 32'(sx), 32'd0);
    check("reset minX", 32'(mnx), 32'd0);
    check("reset minY", 32'(mny), 32'd0);

    // Table of frames: one-cycle latch latency, then values, then ack.
    for (int i = 0; i < 6; i++) begin
      drive_frame(vecs[i].mask, vecs[i].coinc);
      check($sformatf("vec%0d latency", i), 32'(rv), 32'd0);
      step();
      check_res($sformatf("vec%0d", i), vecs[i]);
      check($sformatf("vec%0d overrun", i), 32'(ovr), 32'd0);
      do_ack();
      check($sformatf("vec%0d ack clears", i), 32'(rv), 32'd0);
    end

    // Second frame without ack: first result held, overrun sticky.
    drive_frame(12'h402, 0); step();
    check("ovr first hitCount", 32'(hc), 32'd2);
    drive_frame(12'h080, 0); step();
    check_res("ovr held", vecs[0]);
    check("ovr flag", 32'(ovr), 32'd1);
    do_ack();
    check("ovr ack resultValid", 32'(rv), 32'd0);
    check("ovr sticky after ack", 32'(ovr), 32'd1);
    ack = 1; step(); ack = 0;
    check("ack while idle ignored", 32'(rv), 32'd0);

    // Ack coincident with latch of frame 2.
    reset = 1; step(); reset = 0;
    check("reset clears overrun", 32'(ovr), 32'd0);
    drive_frame(12'h402, 0); step();
    check("ackl first valid", 32'(rv), 32'd1);
    drive_frame(12'h080, 0);
    ack = 1; step(); ack = 0;
    check_res("ackl frame2", vecs[3]);
    check("ackl overrun", 32'(ovr), 32'd0);

    // Reset mid-frame after three hits (result still pending from above).
    sof = 1; step(); sof = 0;
    for (int i = 0; i < 3; i++) begin
      pv = 1; pix = HIT; step();
    end
    clear_in();
    reset = 1; step(); reset = 0;
    check("midrst resultValid", 32'(rv), 32'd0);
    check("midrst hitCount", 32'(hc), 32'd0);
    check("midrst sumY", 32'(sy), 32'd0);
    pv = 1; pix = HIT; eof = 1; step(); clear_in();
    step(); step();
    check("idle eof ignored", 32'(rv), 32'd0);
    drive_frame(12'h001, 0); step();
    v = '{12'h001, 1'b0, 20'd1, 30'd0, 30'd0, 10'd0, 10'd0, 10'd0, 10'd0};
    check_res("postrst", v);
    do_ack();

    // Disabled: startOfFrame is not armed, frame produces nothing.
    enable = 0;
    drive_frame(12'hFFF, 0); step(); step();
    check("disabled no result", 32'(rv), 32'd0);
    // Enable dropping mid-frame lets the frame complete.
    enable = 1; sof = 1; step(); sof = 0; enable = 0;
    pv = 1; pix = HIT; eof = 1; step(); clear_in(); step();
    check("enable drop completes", 32'(rv), 32'd1);
    check("enable drop hitCount", 32'(hc), 32'd1);
    enable = 1;
    do_ack();

    // Restart: startOfFrame mid-frame discards the partial accumulation.
    sof = 1; step(); sof = 0;
    pv = 1; pix = HIT; step(); step(); clear_in();
    drive_frame(12'h080, 0); step();
    check_res("restart", vecs[3]);
    do_ack();

    // x saturates at MAX_DIM on a long line.
    sof = 1; step(); sof = 0;
    for (int i = 0; i < 1030; i++) begin
      pv = 1; pix = (i == 1029) ? HIT : 16'h0000; eof = (i == 1029);
      step();
    end
    clear_in(); step();
    v = '{12'h000, 1'b0, 20'd1, 30'd1023, 30'd0, 10'd1023, 10'd1023, 10'd0, 10'd0};
    check_res("xsat", v);
    do_ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
